// File: rtl/voq_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : voq_bank_if
// Purpose  : Enqueue/dequeue bundle between the crossbar, the VOQ bank and the
//            per-port egress schedulers.
// Revision : 1.0 - initial release
// ============================================================================
interface voq_bank_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 16,
    parameter int VOQ_DEPTH  = 8,
    parameter int DROP_CNT_W = 16
);
    localparam int OCC_W = $clog2(VOQ_DEPTH + 1);

    logic [NUM_PORTS-1:0]  voq_write_reqs_i;
    logic [ADDR_W-1:0]     voq_start_ptrs_i [NUM_PORTS-1:0];
    logic                  flood_i;
    logic [NUM_PORTS-1:0]  deq_ready_i;
    logic [NUM_PORTS-1:0]  deq_valid_o;
    logic [ADDR_W-1:0]     deq_ptr_o        [NUM_PORTS-1:0];
    logic [NUM_PORTS-1:0]  deq_flood_o;
    logic [OCC_W-1:0]      occupancy_o      [NUM_PORTS-1:0];
    logic [NUM_PORTS-1:0]  drop_o;
    logic [DROP_CNT_W-1:0] drop_cnt_o       [NUM_PORTS-1:0];

    // Crossbar / scheduler side: drives requests and pops, observes queues.
    modport master (
        output voq_write_reqs_i, voq_start_ptrs_i, flood_i, deq_ready_i,
        input  deq_valid_o, deq_ptr_o, deq_flood_o, occupancy_o, drop_o, drop_cnt_o
    );

    // Queue bank side.
    modport slave (
        input  voq_write_reqs_i, voq_start_ptrs_i, flood_i, deq_ready_i,
        output deq_valid_o, deq_ptr_o, deq_flood_o, occupancy_o, drop_o, drop_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/voq_bank.sv
`default_nettype none
// ============================================================================
// Module   : voq_bank
// Purpose  : Per-egress virtual output queues. Each port owns an independent
//            circular FIFO of {flood, start pointer} descriptors with
//            show-ahead dequeue and saturating drop counting on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module voq_bank #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_W     = 16,
    parameter int VOQ_DEPTH  = 8,
    parameter int DROP_CNT_W = 16
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    voq_bank_if.slave    bus
);
    localparam int PTR_W = $clog2(VOQ_DEPTH);
    localparam int OCC_W = $clog2(VOQ_DEPTH + 1);
    localparam logic [OCC_W-1:0] c_full = OCC_W'(VOQ_DEPTH);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [ADDR_W:0]     r_mem [VOQ_DEPTH];
        logic [PTR_W-1:0]    r_wptr;
        logic [PTR_W-1:0]    r_rptr;
        logic [OCC_W-1:0]    r_occ;
        logic                r_drop;
        logic [DROP_CNT_W-1:0] r_dcnt;

        logic w_valid;
        logic w_full;
        logic w_pop;
        logic w_push;
        logic w_drop;
        logic [ADDR_W:0] w_head;

        // Handshake decode: a pop frees a slot in the same edge, so a write at
        // full is accepted when it coincides with a pop.
        always_comb begin
            w_valid = (r_occ != '0);
            w_full  = (r_occ == c_full);
            w_pop   = w_valid && bus.deq_ready_i[p];
            w_push  = bus.voq_write_reqs_i[p] && (!w_full || w_pop);
            w_drop  = bus.voq_write_reqs_i[p] && w_full && !w_pop;
            w_head  = r_mem[r_rptr];
        end

        // Descriptor storage; contents need no reset since occupancy gates use.
        always_ff @(posedge clk) begin
            if (rst_n && w_push) begin
                r_mem[r_wptr] <= {bus.flood_i, bus.voq_start_ptrs_i[p]};
            end
        end

        // Pointers, occupancy and drop accounting.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_wptr <= '0;
                r_rptr <= '0;
                r_occ  <= '0;
                r_drop <= 1'b0;
                r_dcnt <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_occ <= r_occ + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_occ <= r_occ - 1'b1;
                end
                r_drop <= w_drop;
                if (w_drop && (r_dcnt != '1)) begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end

        // Head is forced to zero while empty so it stays stable and matches
        // the post-reset value.
        assign bus.deq_valid_o[p] = w_valid;
        assign bus.deq_ptr_o[p]   = w_valid ? w_head[ADDR_W-1:0] : '0;
        assign bus.deq_flood_o[p] = w_valid ? w_head[ADDR_W] : 1'b0;
        assign bus.occupancy_o[p] = r_occ;
        assign bus.drop_o[p]      = r_drop;
        assign bus.drop_cnt_o[p]  = r_dcnt;
    end
endmodule
`default_nettype wire

// File: doc/voq_bank.md
Name: voq_bank

Overview:
- Per-egress virtual output queue bank directly downstream of the crossbar stage.
- Accepts the crossbar's per-port write requests, start pointers and flood flag.
- Each egress port has its own circular FIFO of frame descriptors (start pointer plus flood tag).
- Presents the head descriptor of each port to that port's egress scheduler through a valid/ready handshake, and drops and counts descriptors that arrive at a full queue.

Parameters:
- NUM_PORTS, switch_pkg::NUM_PORTS (4): number of egress ports/queues.
- ADDR_W, mem_pkg::ADDR_W: width of a frame start pointer into packet memory.
- VOQ_DEPTH, 8: descriptors per queue; power of two, ≥2.
- DROP_CNT_W, 16: width of each per-port drop counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- voq_write_reqs_i  in  NUM_PORTS  per-port enqueue strobe; one cycle per frame.
- voq_start_ptrs_i  in  NUM_PORTS x ADDR_W (unpacked array [NUM_PORTS-1:0])  start pointer to enqueue for each requesting port.
- flood_i  in  1  the current enqueue is a flood; tag is stored with every descriptor written this cycle.
- deq_ready_i  in  NUM_PORTS  per-port pop request from the egress scheduler.
- deq_valid_o  out  NUM_PORTS  queue p is non-empty.
- deq_ptr_o  out  NUM_PORTS x ADDR_W  head start pointer of queue p.
- deq_flood_o  out  NUM_PORTS  flood tag of head descriptor of queue p.
- occupancy_o  out  NUM_PORTS x $clog2(VOQ_DEPTH+1)  current entry count per queue.
- drop_o  out  NUM_PORTS  one-cycle pulse: an enqueue to port p was dropped.
- drop_cnt_o  out  NUM_PORTS x DROP_CNT_W  saturating per-port drop count.

Behaviour:
- Reset: when rst_n=0 at a clk edge, all read/write pointers, occupancy, drop_o and drop_cnt_o clear to 0; deq_valid_o=0, deq_ptr_o=0, deq_flood_o=0.
  - Reset mid-operation discards all queued descriptors.
  - Requests presented in the reset cycle are ignored.
- Queues are fully independent. On a flood, all NUM_PORTS requests arrive in one cycle and each queue accepts its request in that same cycle; no serialisation.
- Storage per queue: VOQ_DEPTH entries of {flood, ptr}.
  - Write pointer and read pointer are $clog2(VOQ_DEPTH) bits and wrap modulo VOQ_DEPTH naturally.
  - A separate occupancy counter distinguishes full from empty.
- Push (port p) = voq_write_reqs_i[p] && (occupancy<VOQ_DEPTH || pop[p]).
  - A write at full with a simultaneous pop is accepted; occupancy is unchanged.
- Pop (port p) = deq_valid_o[p] && deq_ready_i[p].
  - deq_ready_i while empty has no effect.
- Show-ahead outputs:
  - deq_ptr_o/deq_flood_o reflect the entry at the read pointer whenever deq_valid_o=1.
  - Value is don't-care but stable when empty.
  - Head advances on the edge after the pop.
- Latency: a descriptor pushed at edge N into an empty queue gives deq_valid_o=1 after edge N. No same-cycle bypass, so a push and ready both asserted on an empty queue only pushes.
- Occupancy update: +1 push only, -1 pop only, unchanged for both or neither.
- Drop: voq_write_reqs_i[p] at occupancy==VOQ_DEPTH without pop[p] discards the descriptor. The edge that would have stored it sets:
  - drop_o[p]=1 (for one cycle);
  - drop_cnt_o[p]+1, saturating at all-ones.
- FIFO order is strictly preserved per queue; no reordering across ports is implied.

Test Plan:
- Unicast basic: after reset, push ptr 0x10 to port 0 with flood_i=0.
  - Next cycle deq_valid_o=4'b0001, deq_ptr_o[0]=0x10, deq_flood_o[0]=0, occupancy_o[0]=1.
  - Pop with deq_ready_i[0]=1 → deq_valid_o[0]=0 next cycle.
- Flood fan-out: push ptr 0x20, write_reqs=4'b1111, flood_i=1.
  - All four queues valid with ptr 0x20 and flood tag 1, occupancy 1 each.
- Fill, wrap and order: push 0x01..0x08 to port 1, pop 3, push 0x09..0x0B.
  - Pops yield 0x04..0x0B in order; write and read pointers wrap; occupancy returns to 0.
- Full and drop: fill port 2 with 8 entries, then push 0x55 without ready.
  - drop_o[2] pulses once; drop_cnt_o[2]=1; occupancy stays 8; head unchanged.
  - A push with simultaneous pop at full is accepted with no drop, and the new entry emerges last.
- Empty push+ready: on empty port 3, assert write_req and deq_ready together with ptr 0x33.
  - Next cycle valid=1, ptr=0x33, occupancy=1; nothing was popped.
- Reset mid-operation: with ports 0–3 holding 2,5,8,1 entries and drop_cnt_o[2]=3, assert rst_n=0 for one edge.
  - All valid=0, occupancy=0, drop_cnt=0.
  - A following push behaves as in the first scenario.
